// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - latches per-source pulse events and queues them round-robin into a FIFO
module button_event_arbiter #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           pulse_in,
  input  logic [WIDTH-1:0]           enable_mask,
  input  logic                       ev_ready,
  input  logic                       clear_drop,
  output logic                       ev_valid,
  output logic [$clog2(WIDTH)-1:0]   ev_id,
  output logic [WIDTH-1:0]           pending,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int IDW = $clog2(WIDTH);
  localparam int AW  = $clog2(DEPTH);
  localparam int SW  = CNT_W + 5;

  logic [WIDTH-1:0] r_pending;
  logic [IDW-1:0]   r_last_grant;
  logic [IDW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_can_grant;
  logic             w_gnt_vld;
  logic [IDW-1:0]   w_gnt_idx;
  logic [WIDTH-1:0] w_gnt_oh;
  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_drop;
  logic [SW-1:0]    w_drop_k;
  logic [SW-1:0]    w_drop_sum;
  logic             w_pop;

  // A full FIFO blocks grants even when the head is popped this cycle.
  assign w_can_grant = (|r_pending) && (r_count != (AW+1)'(DEPTH));
  assign w_pop       = ev_valid && ev_ready;
  assign w_accept    = pulse_in & enable_mask;
  assign w_drop      = w_accept & r_pending & ~w_gnt_oh;

  always_comb begin
    int j;
    j         = 0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (w_can_grant) begin
      for (int k = 1; k <= WIDTH; k++) begin
        j = int'(r_last_grant) + k;
        if (j >= WIDTH) j = j - WIDTH;
        if (!w_gnt_vld && r_pending[j]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = IDW'(j);
        end
      end
    end
  end

  assign w_gnt_oh = w_gnt_vld ? (WIDTH'(1) << w_gnt_idx) : '0;

  always_comb begin
    w_drop_k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_drop_k = w_drop_k + SW'(w_drop[i]);
    end
  end

  assign w_drop_sum = SW'(r_drop_cnt) + w_drop_k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending    <= '0;
      r_last_grant <= IDW'(WIDTH - 1);
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_drop_cnt   <= '0;
    end else begin
      // A pulse arriving on the granted source re-arms its pending bit.
      r_pending <= (r_pending & ~w_gnt_oh) | w_accept;
      if (w_gnt_vld) begin
        r_last_grant <= w_gnt_idx;
        r_wr_ptr     <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_gnt_vld, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (clear_drop) begin
        r_drop_cnt <= '0;
      end else if (|w_drop_sum[SW-1:CNT_W]) begin
        r_drop_cnt <= '1;
      end else begin
        r_drop_cnt <= w_drop_sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_gnt_vld) begin
      r_mem[r_wr_ptr] <= w_gnt_idx;
    end
  end

  assign ev_valid   = (r_count != '0);
  assign ev_id      = ev_valid ? r_mem[r_rd_ptr] : '0;
  assign pending    = r_pending;
  assign fifo_count = r_count;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: doc/button_event_arbiter.md
BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of event sources (2..8).
REQ-002 SHALL have parameter DEPTH, default 4, event FIFO entries (power of 2, 2..16).
REQ-003 SHALL have parameter CNT_W, default 8, drop-counter width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port pulse_in  input  WIDTH  single-cycle edge pulses, one per source.
REQ-007 SHALL have port enable_mask  input  WIDTH  per-source enable, 1 = accept pulses.
REQ-008 SHALL have port ev_ready  input  1  consumer accepts head event.
REQ-009 SHALL have port clear_drop  input  1  synchronous clear of drop_cnt.
REQ-010 SHALL have port ev_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port ev_id  output  clog2(WIDTH)  source index of head event.
REQ-012 SHALL have port pending  output  WIDTH  latched, not-yet-queued events.
REQ-013 SHALL have port fifo_count  output  clog2(DEPTH)+1  entries held.
REQ-014 SHALL have port drop_cnt  output  CNT_W  saturating count of lost pulses.

Function
REQ-015 pending[i] SHALL be set at the edge where pulse_in[i]=1 and enable_mask[i]=1.
REQ-016 pending[i] SHALL be cleared only by a grant to source i; clearing enable_mask[i] SHALL NOT clear pending[i].
REQ-017 Arbiter SHALL grant at most one source per cycle when pending!=0 and fifo_count<DEPTH; fifo_count==DEPTH SHALL stall grants even if a pop occurs the same cycle.
REQ-018 Grant SHALL be round-robin: search starts at index last_grant+1, wrapping from WIDTH-1 to 0; last_grant SHALL update to the granted index.
REQ-019 A grant SHALL push the granted index into the FIFO tail and clear that pending bit at the same edge.
REQ-020 A pulse on source i in the same cycle source i is granted SHALL leave pending[i]=1 (new event, not dropped).
REQ-021 A pulse on an enabled source whose pending bit is 1 and is not granted that cycle SHALL increment drop_cnt by 1; simultaneous drops on k sources SHALL add k.
REQ-022 drop_cnt SHALL saturate at all-ones; clear_drop=1 SHALL zero it with priority over any increment that cycle.
REQ-023 Pulses on disabled sources SHALL be ignored (neither pending nor dropped).
REQ-024 ev_valid SHALL equal (fifo_count!=0); ev_id SHALL present the head entry whenever ev_valid=1.
REQ-025 A pop SHALL occur when ev_valid=1 and ev_ready=1; ev_ready while empty SHALL have no effect.
REQ-026 Simultaneous push and pop SHALL leave fifo_count unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-027 Latency: pulse sampled at edge t with idle arbiter and empty FIFO SHALL yield ev_valid=1 after edge t+1 (pending visible after edge t).
REQ-028 FIFO order SHALL equal grant order; no event SHALL be reordered or duplicated.

Reset
REQ-029 rst_n=0 SHALL immediately force pending=0, fifo_count=0, ev_valid=0, drop_cnt=0, FIFO pointers=0, last_grant=WIDTH-1.
REQ-030 ev_id SHALL read 0 during and after reset until the first push.
REQ-031 Reset asserted mid-operation SHALL discard all queued and pending events; first post-reset grant SHALL search from index 0.

Verification
REQ-032 Single pulse on source 2, ev_ready=0 -> pending=0100 after edge t, ev_valid=1, ev_id=2, fifo_count=1 after t+1; ev_ready=1 one cycle -> ev_valid=0, fifo_count=0.
REQ-033 All four pulses same cycle, ev_ready=0 -> ids pushed 0,1,2,3 on four consecutive edges, fifo_count=4; popping returns 0,1,2,3.
REQ-034 After last grant=1, pulses on sources 0 and 3 together -> grant 3 then 0.
REQ-035 FIFO full, pending[0]=1, two further pulses on source 0 -> drop_cnt=2, pending unchanged; one pop -> next cycle grants source 0, pending[0]=0.
REQ-036 drop_cnt at 255 with further drop -> stays 255; clear_drop plus drop same cycle -> 0.
REQ-037 rst_n low with fifo_count=3 and pending=1010 -> all outputs 0 immediately; pulse on source 3 after release -> ev_id=3 two edges later.
